// File: rtl/aes_enc_iter_ctrl_if.sv
// Bundle of stream, key-store and round-datapath signals for aes_enc_iter_ctrl.
//   master : controller side (drives in_ready, rk_addr, round_in, last_round,
//            out_valid, ciphertext, busy)
//   slave  : environment side (source, key store, round datapath, sink)
interface aes_enc_iter_ctrl_if;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] round_in;
  logic         last_round;
  logic [127:0] round_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    input  key_ready, in_valid, plaintext, rk_data, round_out, out_ready,
    output in_ready, rk_addr, round_in, last_round, out_valid, ciphertext, busy
  );

  modport slave (
    output key_ready, in_valid, plaintext, rk_data, round_out, out_ready,
    input  in_ready, rk_addr, round_in, last_round, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes_enc_iter_ctrl.sv
// Iterative AES encryption sequencer. One shared round datapath (external,
// combinational) is reused for all ROUNDS passes; the initial AddRoundKey with
// key 0 is folded into the accept cycle. One block in flight; the result is
// held until the consumer takes it.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : stream in (in_valid/in_ready/plaintext), key store
//              (key_ready, rk_addr, rk_data), round datapath (round_in,
//              last_round, round_out), stream out (out_valid/out_ready/
//              ciphertext) and busy
// NK must be 4, 6 or 8; the round count is derived from it.
module aes_enc_iter_ctrl #(
  parameter int unsigned NK = 4
) (
  input logic               clk,
  input logic               rst,
  aes_enc_iter_ctrl_if.master bus
);

  localparam int unsigned ROUNDS  = NK + 6;
  localparam logic [3:0]  RoundsW = 4'(ROUNDS);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;

  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    data_d = data_q;
    case (fsm_q)
      StIdle: begin
        if (bus.in_valid && bus.key_ready) begin
          // rk_addr is 0 here, so rk_data is round key 0
          data_d = bus.plaintext ^ bus.rk_data;
          rnd_d  = 4'd1;
          fsm_d  = StRound;
        end
      end
      StRound: begin
        data_d = bus.round_out;
        if (rnd_q == RoundsW) begin
          rnd_d = 4'd0;
          fsm_d = StDone;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          fsm_d = StIdle;
        end
      end
      default: begin
        fsm_d = StIdle;
        rnd_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= StIdle;
      rnd_q  <= 4'd0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    bus.in_ready   = (fsm_q == StIdle) && bus.key_ready;
    bus.rk_addr    = (fsm_q == StRound) ? rnd_q : 4'd0;
    bus.round_in   = data_q;
    bus.last_round = (fsm_q == StRound) && (rnd_q == RoundsW);
    bus.out_valid  = (fsm_q == StDone);
    bus.ciphertext = data_q;
    bus.busy       = (fsm_q == StRound) || (fsm_q == StDone);
  end

endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
// Bench for aes_enc_iter_ctrl: three controllers (NK = 4, 6, 8), each with its
// own key store and AES round datapath model. Ciphertexts are checked by a
// scoreboard against FIPS-197 reference vectors.
module tb_aes_enc_iter_ctrl;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY   =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]   in_valid  = '0;
  logic [2:0]   out_ready = '0;
  logic [2:0]   key_ready = 3'b111;
  logic [127:0] plaintext = '0;

  logic [2:0]   in_ready_w, out_valid_w, busy_w, last_round_w;
  logic [3:0]   rk_addr_w [3];
  logic [127:0] ct_w      [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           inst;
    logic [127:0] ct;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AES reference helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base, s;
    inv = 8'h01; base = x;
    for (int k = 0; k < 8; k++) begin  // x^254 is the GF(2^8) inverse (0 -> 0)
      if (k != 0) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] round_key(input int nk, input int r);
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [255:0] key;
    key = KEY; rc = 8'h01;
    for (int i = 0; i < 4 * (r + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32 * i -: 32];
      end else begin
        tmp = w[i-1];
        if (i % nk == 0) begin
          tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc  = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          tmp = sub_word(tmp);
        end
        w[i] = w[i-nk] ^ tmp;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   m [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[127 - 8 * i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r + 4 * c] = s[r + 4 * ((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
      m[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
      m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
      m[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
    end
    for (int i = 0; i < 16; i++)
      res[127 - 8 * i -: 8] = (last ? t[i] : m[i]) ^ rk[127 - 8 * i -: 8];
    return res;
  endfunction

  // ---------------- DUT instances with their environments ----------------
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned Nk = 4 + 2 * g;
    aes_enc_iter_ctrl_if bus ();
    logic [127:0] rks [16];

    initial for (int r = 0; r < 16; r++)
      rks[r] = (r <= int'(Nk) + 6) ? round_key(int'(Nk), r) : '0;

    assign bus.key_ready = key_ready[g];
    assign bus.in_valid  = in_valid[g];
    assign bus.out_ready = out_ready[g];
    assign bus.plaintext = plaintext;
    assign bus.rk_data   = rks[bus.rk_addr];
    assign bus.round_out = aes_round(bus.round_in, bus.rk_data, bus.last_round);

    assign in_ready_w[g]   = bus.in_ready;
    assign out_valid_w[g]  = bus.out_valid;
    assign busy_w[g]       = bus.busy;
    assign last_round_w[g] = bus.last_round;
    assign rk_addr_w[g]    = bus.rk_addr;
    assign ct_w[g]         = bus.ciphertext;

    aes_enc_iter_ctrl #(.NK(Nk)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst && out_valid_w[g] && out_ready[g]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: inst %0d output %h with nothing expected", g, ct_w[g]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_inst", 128'(g), 128'(e.inst));
          check("sb_ct", ct_w[g], e.ct);
        end
      end
    end
  end

  // ---------------- stimulus tasks (enter and leave just after a posedge) ----------------
  task automatic accept(input int g, input logic [127:0] pt);
    int n;
    n = 0;
    in_valid[g] = 1'b1;
    plaintext   = pt;
    @(negedge clk);
    while (!in_ready_w[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_seen", 128'(in_ready_w[g]), 128'd1);
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic run_block(input int g, input logic [127:0] pt, input logic [127:0] ct,
                           input int lat);
    int n;
    exp_t e;
    out_ready[g] = 1'b1;
    e.inst = g; e.ct = ct;
    exp_q.push_back(e);
    accept(g, pt);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_w[g] && n < 40);
    check("latency", 128'(n), 128'(lat));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_out_valid", 128'(out_valid_w[g]), 128'd0);
    check("post_busy", 128'(busy_w[g]), 128'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    int   acc [3];
    exp_t e;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready_w[0]), 128'd1);
    check("rst_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("rst_busy", 128'(busy_w[0]), 128'd0);
    check("rst_last_round", 128'(last_round_w[0]), 128'd0);
    check("rst_rk_addr", 128'(rk_addr_w[0]), 128'd0);
    check("rst_ct", ct_w[0], 128'd0);
    @(posedge clk); #1;

    // AES-128/192/256 known answers
    run_block(0, PT, CT128, 11);
    run_block(1, PT, CT192, 13);
    run_block(2, PT, CT256, 15);

    // backpressure in DONE for 5 cycles
    out_ready[0] = 1'b0;
    e.inst = 0; e.ct = CT128;
    exp_q.push_back(e);
    accept(0, PT);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_w[0] && n < 40);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 128'(out_valid_w[0]), 128'd1);
      check("bp_ct_stable", ct_w[0], CT128);
      check("bp_in_ready", 128'(in_ready_w[0]), 128'd0);
      @(posedge clk); #1;
      if (i == 4) out_ready[0] = 1'b1;
      @(negedge clk);
    end
    check("bp_valid_at_hs", 128'(out_valid_w[0]), 128'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_valid", 128'(out_valid_w[0]), 128'd0);
    check("bp_idle_in_ready", 128'(in_ready_w[0]), 128'd1);
    @(posedge clk); #1;

    // key_ready gating, then rk_addr / last_round sequence
    key_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    plaintext    = PT;
    repeat (3) begin
      @(negedge clk);
      check("kr_in_ready", 128'(in_ready_w[0]), 128'd0);
      check("kr_busy", 128'(busy_w[0]), 128'd0);
      @(posedge clk); #1;
    end
    key_ready[0] = 1'b1;
    @(negedge clk);
    check("kr_in_ready_rise", 128'(in_ready_w[0]), 128'd1);
    check("kr_rk_addr0", 128'(rk_addr_w[0]), 128'd0);
    e.inst = 0; e.ct = CT128;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("seq_rk_addr", 128'(rk_addr_w[0]), 128'(k));
      check("seq_last_round", 128'(last_round_w[0]), 128'(k == 10));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("seq_out_valid", 128'(out_valid_w[0]), 128'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // reset at rnd=5 aborts the block
    accept(0, PT);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_rk_addr5", 128'(rk_addr_w[0]), 128'd5);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 128'(busy_w[0]), 128'd0);
    check("abort_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("abort_ct_cleared", ct_w[0], 128'd0);
    check("abort_in_ready", 128'(in_ready_w[0]), 128'd1);
    repeat (12) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_no_output", 128'(out_valid_w[0]), 128'd0);
    @(posedge clk); #1;
    run_block(0, PT, CT128, 11);

    // back-to-back with in_valid held
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.inst = 0; e.ct = CT128;
      exp_q.push_back(e);
    end
    in_valid[0] = 1'b1;
    plaintext   = PT;
    n = 0;
    for (int k = 0; k < 100 && n < 3; k++) begin
      @(negedge clk);
      if (in_ready_w[0]) begin
        acc[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("b2b_accepts", 128'(n), 128'd3);
    check("b2b_gap1", 128'(acc[1] - acc[0]), 128'd12);
    check("b2b_gap2", 128'(acc[2] - acc[1]), 128'd12);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("sb_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
             errors, checks);
    $fatal(1);
  end

endmodule
